// File: rtl/fetch_32.sv
// Instruction fetch stage: single-outstanding imem requests into a small head-registered FIFO.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirect targets raise misalign_out and halt fetch.
module fetch_32 #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH   = 2
) (
   input  logic        clk_in,
   input  logic        reset_in,
   input  logic        stall_in,
   input  logic        redirect_in,
   input  logic [31:0] redirect_pc_in,
   output logic        imem_req_out,
   output logic [31:0] imem_addr_out,
   input  logic        imem_ack_in,
   input  logic [31:0] imem_data_in,
   output logic [31:0] insn_out,
   output logic [31:0] insn_pc_out,
   output logic        insn_valid_out,
   output logic        misalign_out
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 2) ? 2 : 1;
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_DISCARD
   } state_t;

   state_t            state_q, state_d;
   logic [31:0]       fetch_pc_q, fetch_pc_d;
   logic [31:0]       addr_q, addr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [31:0]       data_q [FIFO_DEPTH];
   logic [31:0]       pcbuf_q [FIFO_DEPTH];

   logic              fifo_valid;
   logic              pop;
   logic              push;
   logic              bad_tgt;
   logic              trap_block;
   logic              can_issue;
   logic [CNT_W-1:0]  count_after;
   logic [31:0]       pc_inc;
   logic [31:0]       redirect_tgt;

`ifdef FETCH_MISALIGN_TRAP_EN
   logic misalign_q;
   logic trap_q;

   assign bad_tgt = |redirect_pc_in[1:0];

   // The trap latch is only re-evaluated by a redirect, so fetch stays halted until then.
   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in) begin
         misalign_q <= 1'b0;
         trap_q     <= 1'b0;
      end else begin
         misalign_q <= redirect_in & bad_tgt;
         if (redirect_in) begin
            trap_q <= bad_tgt;
         end
      end
   end

   assign misalign_out = misalign_q;
   assign trap_block   = trap_q;
`else
   logic unused_lowbits;

   assign bad_tgt        = 1'b0;
   assign unused_lowbits = ^{redirect_pc_in[1:0], bad_tgt};
   assign misalign_out   = 1'b0;
   assign trap_block     = 1'b0;
`endif

   assign redirect_tgt = {redirect_pc_in[31:2], 2'b00};
   assign fifo_valid   = (count_q != '0);
   assign pop          = fifo_valid & ~stall_in & ~redirect_in;
   assign push         = (state_q == S_WAIT) & imem_ack_in & ~redirect_in;
   assign count_after  = count_q + CNT_W'(push) - CNT_W'(pop);
   assign pc_inc       = fetch_pc_q + 32'd4;
   assign can_issue    = ~redirect_in & ~trap_block;

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      addr_d     = addr_q;
      count_d    = count_after;
      rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
      wr_ptr_d   = wr_ptr_q + PTR_W'(push);

      unique case (state_q)
         S_IDLE: begin
            if (can_issue && (count_q < DEPTH_C)) begin
               state_d = S_WAIT;
               addr_d  = fetch_pc_q;
            end
         end
         S_WAIT: begin
            if (imem_ack_in) begin
               fetch_pc_d = pc_inc;
               // Chain the next request off the ack when the write still leaves room.
               if (can_issue && (count_after < DEPTH_C)) begin
                  addr_d = pc_inc;
               end else begin
                  state_d = S_IDLE;
               end
            end else if (redirect_in) begin
               state_d = S_DISCARD;
            end
         end
         S_DISCARD: begin
            if (imem_ack_in) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (redirect_in) begin
         fetch_pc_d = redirect_tgt;
         count_d    = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
      end
   end

   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in) begin
         state_q    <= S_IDLE;
         fetch_pc_q <= {RESET_VECTOR[31:2], 2'b00};
         addr_q     <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         addr_q     <= addr_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
      end
   end

   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in) begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            data_q[i]  <= '0;
            pcbuf_q[i] <= '0;
         end
      end else if (push) begin
         data_q[wr_ptr_q]  <= imem_data_in;
         pcbuf_q[wr_ptr_q] <= addr_q;
      end
   end

   assign imem_req_out   = (state_q == S_WAIT);
   assign imem_addr_out  = addr_q;
   assign insn_valid_out = fifo_valid;
   assign insn_out       = fifo_valid ? data_q[rd_ptr_q]  : '0;
   assign insn_pc_out    = fifo_valid ? pcbuf_q[rd_ptr_q] : '0;

`ifndef SYNTHESIS
   a_req_stable : assert property (@(posedge clk_in) disable iff (!reset_in)
      (imem_req_out && !imem_ack_in && !redirect_in) |=> (imem_req_out && $stable(imem_addr_out)));
   a_addr_aligned : assert property (@(posedge clk_in) disable iff (!reset_in)
      imem_addr_out[1:0] == 2'b00);
   a_count_bound : assert property (@(posedge clk_in) disable iff (!reset_in)
      count_q <= DEPTH_C);
`endif

endmodule

// File: tb/tb_fetch_32.sv
// Directed-vector bench for fetch_32; memory either acks in the request cycle or is driven by hand.
module tb_fetch_32;

   logic        clk_in = 1'b0;
   logic        reset_in;
   logic        stall_in;
   logic        redirect_in;
   logic [31:0] redirect_pc_in;
   logic        imem_req_out;
   logic [31:0] imem_addr_out;
   logic        imem_ack_in;
   logic [31:0] imem_data_in;
   logic [31:0] insn_out;
   logic [31:0] insn_pc_out;
   logic        insn_valid_out;
   logic        misalign_out;

   logic        auto_ack;
   logic        man_ack;
   logic [31:0] man_data;

   int errors = 0;
   int checks = 0;

`ifdef FETCH_MISALIGN_TRAP_EN
   localparam logic TRAP_EN = 1'b1;
`else
   localparam logic TRAP_EN = 1'b0;
`endif

   always #5 clk_in = ~clk_in;

   // Memory word for address a is a + 32'h1000_0000.
   assign imem_ack_in  = auto_ack ? imem_req_out : man_ack;
   assign imem_data_in = auto_ack ? (imem_addr_out + 32'h1000_0000) : man_data;

   fetch_32 #(.RESET_VECTOR(32'h0000_0000), .FIFO_DEPTH(2)) dut (
      .clk_in         (clk_in),
      .reset_in       (reset_in),
      .stall_in       (stall_in),
      .redirect_in    (redirect_in),
      .redirect_pc_in (redirect_pc_in),
      .imem_req_out   (imem_req_out),
      .imem_addr_out  (imem_addr_out),
      .imem_ack_in    (imem_ack_in),
      .imem_data_in   (imem_data_in),
      .insn_out       (insn_out),
      .insn_pc_out    (insn_pc_out),
      .insn_valid_out (insn_valid_out),
      .misalign_out   (misalign_out)
   );

   task automatic start_run(input logic auto, input logic redir, input logic [31:0] rpc);
      reset_in       = 1'b0;
      stall_in       = 1'b0;
      redirect_in    = redir;
      redirect_pc_in = rpc;
      auto_ack       = auto;
      man_ack        = 1'b0;
      man_data       = '0;
      @(negedge clk_in);
      @(negedge clk_in);
      reset_in = 1'b1;
   endtask

   task automatic test_reset();
      reset_in = 1'b0; stall_in = 1'b0; redirect_in = 1'b0; redirect_pc_in = 32'h0000_0104;
      auto_ack = 1'b1; man_ack = 1'b0; man_data = '0;
      @(negedge clk_in);
      @(negedge clk_in);
      checks++; if (imem_req_out !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", imem_req_out); end
      checks++; if (imem_addr_out !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=00000000", imem_addr_out); end
      checks++; if (insn_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", insn_valid_out); end
      checks++; if (insn_out !== 32'h0) begin errors++; $display("FAIL reset_insn got=%h exp=00000000", insn_out); end
      checks++; if (insn_pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=00000000", insn_pc_out); end
      checks++; if (misalign_out !== 1'b0) begin errors++; $display("FAIL reset_misalign got=%b exp=0", misalign_out); end
   endtask

   task automatic test_stream();
      start_run(1'b1, 1'b0, 32'h0);
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk_in);
         checks++; if (imem_req_out !== 1'b1) begin errors++; $display("FAIL stream_req k=%0d got=%b exp=1", k, imem_req_out); end
         checks++; if (imem_addr_out !== 32'(4 * (k - 1))) begin errors++; $display("FAIL stream_addr k=%0d got=%h exp=%h", k, imem_addr_out, 32'(4 * (k - 1))); end
         checks++; if (insn_valid_out !== (k >= 2)) begin errors++; $display("FAIL stream_valid k=%0d got=%b exp=%b", k, insn_valid_out, (k >= 2)); end
         if (k >= 2) begin
            checks++; if (insn_pc_out !== 32'(4 * (k - 2))) begin errors++; $display("FAIL stream_pc k=%0d got=%h exp=%h", k, insn_pc_out, 32'(4 * (k - 2))); end
            checks++; if (insn_out !== 32'(4 * (k - 2)) + 32'h1000_0000) begin errors++; $display("FAIL stream_insn k=%0d got=%h", k, insn_out); end
         end
      end
   endtask

   task automatic test_stall();
      logic [31:0] exp_pc;
      int got;
      start_run(1'b1, 1'b0, 32'h0);
      stall_in = 1'b1;
      for (int n = 1; n <= 5; n++) begin
         @(negedge clk_in);
         if (n >= 3) begin
            checks++; if (imem_req_out !== 1'b0) begin errors++; $display("FAIL stall_req n=%0d got=%b exp=0", n, imem_req_out); end
            checks++; if (insn_valid_out !== 1'b1) begin errors++; $display("FAIL stall_valid n=%0d got=%b exp=1", n, insn_valid_out); end
            checks++; if (insn_pc_out !== 32'h0) begin errors++; $display("FAIL stall_head n=%0d got=%h exp=00000000", n, insn_pc_out); end
         end
      end
      stall_in = 1'b0;
      exp_pc = 32'h0;
      got = 0;
      for (int i = 0; i < 8; i++) begin
         if (insn_valid_out === 1'b1) begin
            checks++; if (insn_pc_out !== exp_pc) begin errors++; $display("FAIL stall_drain_pc i=%0d got=%h exp=%h", i, insn_pc_out, exp_pc); end
            checks++; if (insn_out !== exp_pc + 32'h1000_0000) begin errors++; $display("FAIL stall_drain_insn i=%0d got=%h exp=%h", i, insn_out, exp_pc + 32'h1000_0000); end
            exp_pc += 32'd4;
            got++;
         end
         @(negedge clk_in);
      end
      checks++; if (got !== 7) begin errors++; $display("FAIL stall_drain_count got=%0d exp=7", got); end
   endtask

   task automatic test_redirect_discard();
      start_run(1'b0, 1'b1, 32'h0000_0010);
      @(negedge clk_in);
      redirect_in = 1'b0;
      checks++; if (imem_req_out !== 1'b0) begin errors++; $display("FAIL disc_hold_req got=%b exp=0", imem_req_out); end
      @(negedge clk_in);
      checks++; if (imem_req_out !== 1'b1) begin errors++; $display("FAIL disc_req10 got=%b exp=1", imem_req_out); end
      checks++; if (imem_addr_out !== 32'h10) begin errors++; $display("FAIL disc_addr10 got=%h exp=00000010", imem_addr_out); end
      redirect_in = 1'b1; redirect_pc_in = 32'h0000_0100;
      @(negedge clk_in);
      redirect_in = 1'b0;
      checks++; if (imem_req_out !== 1'b0) begin errors++; $display("FAIL disc_req_drop got=%b exp=0", imem_req_out); end
      checks++; if (insn_valid_out !== 1'b0) begin errors++; $display("FAIL disc_valid3 got=%b exp=0", insn_valid_out); end
      @(negedge clk_in);
      checks++; if (imem_req_out !== 1'b0) begin errors++; $display("FAIL disc_req4 got=%b exp=0", imem_req_out); end
      man_ack = 1'b1; man_data = 32'hDEAD_0010;
      @(negedge clk_in);
      man_ack = 1'b0;
      checks++; if (insn_valid_out !== 1'b0) begin errors++; $display("FAIL disc_dropped got=%b pc=%h exp=0", insn_valid_out, insn_pc_out); end
      checks++; if (imem_req_out !== 1'b0) begin errors++; $display("FAIL disc_req5 got=%b exp=0", imem_req_out); end
      @(negedge clk_in);
      checks++; if (imem_req_out !== 1'b1) begin errors++; $display("FAIL disc_req100 got=%b exp=1", imem_req_out); end
      checks++; if (imem_addr_out !== 32'h100) begin errors++; $display("FAIL disc_addr100 got=%h exp=00000100", imem_addr_out); end
      checks++; if (insn_valid_out !== 1'b0) begin errors++; $display("FAIL disc_valid6 got=%b exp=0", insn_valid_out); end
      auto_ack = 1'b1;
      @(negedge clk_in);
      checks++; if (insn_valid_out !== 1'b1) begin errors++; $display("FAIL disc_first_valid got=%b exp=1", insn_valid_out); end
      checks++; if (insn_pc_out !== 32'h100) begin errors++; $display("FAIL disc_first_pc got=%h exp=00000100", insn_pc_out); end
      checks++; if (insn_out !== 32'h1000_0100) begin errors++; $display("FAIL disc_first_insn got=%h exp=10000100", insn_out); end
   endtask

   task automatic test_redirect_ack();
      start_run(1'b1, 1'b0, 32'h0);
      @(negedge clk_in);
      checks++; if (imem_addr_out !== 32'h0) begin errors++; $display("FAIL rack_addr0 got=%h exp=00000000", imem_addr_out); end
      redirect_in = 1'b1; redirect_pc_in = 32'h0000_0200;
      @(negedge clk_in);
      redirect_in = 1'b0;
      checks++; if (insn_valid_out !== 1'b0) begin errors++; $display("FAIL rack_acked_word got=%b pc=%h exp=0", insn_valid_out, insn_pc_out); end
      checks++; if (imem_req_out !== 1'b0) begin errors++; $display("FAIL rack_req2 got=%b exp=0", imem_req_out); end
      @(negedge clk_in);
      checks++; if (imem_addr_out !== 32'h200) begin errors++; $display("FAIL rack_addr200 got=%h exp=00000200", imem_addr_out); end
      checks++; if (insn_valid_out !== 1'b0) begin errors++; $display("FAIL rack_valid3 got=%b exp=0", insn_valid_out); end
      @(negedge clk_in);
      checks++; if (insn_pc_out !== 32'h200) begin errors++; $display("FAIL rack_pc200 got=%h exp=00000200", insn_pc_out); end
      checks++; if (insn_out !== 32'h1000_0200) begin errors++; $display("FAIL rack_insn200 got=%h exp=10000200", insn_out); end
      stall_in = 1'b1;
      @(negedge clk_in);
      checks++; if (imem_req_out !== 1'b0) begin errors++; $display("FAIL rack_full_req got=%b exp=0", imem_req_out); end
      checks++; if (insn_pc_out !== 32'h200) begin errors++; $display("FAIL rack_stall_pc got=%h exp=00000200", insn_pc_out); end
      redirect_in = 1'b1; redirect_pc_in = 32'h0000_0300;
      @(negedge clk_in);
      redirect_in = 1'b0; stall_in = 1'b0;
      checks++; if (insn_valid_out !== 1'b0) begin errors++; $display("FAIL rack_flush got=%b exp=0", insn_valid_out); end
      @(negedge clk_in);
      checks++; if (imem_addr_out !== 32'h300) begin errors++; $display("FAIL rack_addr300 got=%h exp=00000300", imem_addr_out); end
   endtask

   task automatic test_wrap();
      start_run(1'b1, 1'b1, 32'hFFFF_FFFC);
      @(negedge clk_in);
      redirect_in = 1'b0;
      @(negedge clk_in);
      checks++; if (imem_addr_out !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_top got=%h exp=fffffffc", imem_addr_out); end
      @(negedge clk_in);
      checks++; if (imem_addr_out !== 32'h0) begin errors++; $display("FAIL wrap_zero got=%h exp=00000000", imem_addr_out); end
      checks++; if (insn_pc_out !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc got=%h exp=fffffffc", insn_pc_out); end
      checks++; if (insn_out !== 32'h0FFF_FFFC) begin errors++; $display("FAIL wrap_insn got=%h exp=0ffffffc", insn_out); end
   endtask

   task automatic test_misalign();
      start_run(1'b1, 1'b1, 32'h0000_0102);
      @(negedge clk_in);
      redirect_in = 1'b0;
      checks++; if (misalign_out !== TRAP_EN) begin errors++; $display("FAIL mis_pulse got=%b exp=%b", misalign_out, TRAP_EN); end
      @(negedge clk_in);
      checks++; if (misalign_out !== 1'b0) begin errors++; $display("FAIL mis_one_cycle got=%b exp=0", misalign_out); end
      checks++; if (imem_req_out !== ~TRAP_EN) begin errors++; $display("FAIL mis_req got=%b exp=%b", imem_req_out, ~TRAP_EN); end
`ifndef FETCH_MISALIGN_TRAP_EN
      checks++; if (imem_addr_out !== 32'h100) begin errors++; $display("FAIL mis_masked_addr got=%h exp=00000100", imem_addr_out); end
`endif
      @(negedge clk_in);
      checks++; if (insn_valid_out !== ~TRAP_EN) begin errors++; $display("FAIL mis_valid got=%b exp=%b", insn_valid_out, ~TRAP_EN); end
      redirect_in = 1'b1; redirect_pc_in = 32'h0000_0040;
      @(negedge clk_in);
      redirect_in = 1'b0;
      checks++; if (misalign_out !== 1'b0) begin errors++; $display("FAIL mis_aligned_clear got=%b exp=0", misalign_out); end
      @(negedge clk_in);
      checks++; if (imem_req_out !== 1'b1) begin errors++; $display("FAIL mis_resume_req got=%b exp=1", imem_req_out); end
      checks++; if (imem_addr_out !== 32'h40) begin errors++; $display("FAIL mis_resume_addr got=%h exp=00000040", imem_addr_out); end
   endtask

   task automatic test_reset_mid();
      start_run(1'b0, 1'b0, 32'h0);
      @(negedge clk_in);
      checks++; if (imem_req_out !== 1'b1) begin errors++; $display("FAIL rmid_req got=%b exp=1", imem_req_out); end
      #2 reset_in = 1'b0;
      #1;
      checks++; if (imem_req_out !== 1'b0) begin errors++; $display("FAIL rmid_async_req got=%b exp=0", imem_req_out); end
      @(negedge clk_in);
      reset_in = 1'b1; man_ack = 1'b1; man_data = 32'hBAD0_0000;
      @(negedge clk_in);
      man_ack = 1'b0;
      checks++; if (imem_req_out !== 1'b1) begin errors++; $display("FAIL rmid_new_req got=%b exp=1", imem_req_out); end
      checks++; if (insn_valid_out !== 1'b0) begin errors++; $display("FAIL rmid_stale_ack got=%b insn=%h exp=0", insn_valid_out, insn_out); end
      @(negedge clk_in);
      checks++; if (insn_valid_out !== 1'b0) begin errors++; $display("FAIL rmid_valid4 got=%b exp=0", insn_valid_out); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_redirect_discard();
      test_redirect_ack();
      test_wrap();
      test_misalign();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
